// File: rtl/cpu_lsu.sv
// In-order load/store unit with a DEPTH-entry request queue.
// Execute pushes LOAD/STORE requests. The head entry is issued to the memory
// port as a one-cycle strobe, and the unit waits in WAIT for the matching
// acknowledge. Load data goes back to writeback as a one-cycle pulse.
// Each access is bounded by a timeout, which sets a sticky error flag.
// flush drops every queued request that has not been issued yet.
module cpu_lsu #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 11,
    parameter int DEST_W  = 6,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_is_store,
    input  logic [ADDR_W-1:0]          req_addr,
    input  logic [DATA_W-1:0]          req_wdata,
    input  logic [DEST_W-1:0]          req_dest,
    output logic                       mem_read,
    output logic                       mem_write,
    output logic [ADDR_W-1:0]          mem_adrs,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic [DATA_W-1:0]          mem_rdata,
    input  logic                       read_load_valid,
    input  logic                       write_store_valid,
    output logic                       wb_valid,
    output logic [DEST_W-1:0]          wb_dest,
    output logic [DATA_W-1:0]          wb_data,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] pending,
    output logic                       error
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // Queue storage. The head entry is read directly, because the issue logic
    // needs it in the same cycle that it decides to leave IDLE.
    logic              q_is_store [DEPTH];
    logic [ADDR_W-1:0] q_addr     [DEPTH];
    logic [DATA_W-1:0] q_wdata    [DEPTH];
    logic [DEST_W-1:0] q_dest     [DEPTH];

    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [CNT_W-1:0]  count_reg;

    state_t            state_reg, state_next;
    logic [TO_W-1:0]   wait_cnt_reg, wait_cnt_next;

    logic              mem_read_reg, mem_read_next;
    logic              mem_write_reg, mem_write_next;
    logic [ADDR_W-1:0] mem_adrs_reg, mem_adrs_next;
    logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
    logic              wb_valid_reg, wb_valid_next;
    logic [DEST_W-1:0] wb_dest_reg, wb_dest_next;
    logic [DATA_W-1:0] wb_data_reg, wb_data_next;
    logic              error_reg, error_next;

    logic              push;
    logic              pop;
    logic              head_is_store;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_wdata;
    logic [DEST_W-1:0] head_dest;
    logic              ack_match;

    // The full check uses the registered count only. A pop in the same cycle
    // therefore never frees a slot for a push.
    assign req_ready = (count_reg < CNT_W'(DEPTH));
    // A request that arrives in the same cycle as flush is dropped.
    assign push      = req_valid && req_ready && !flush;

    assign head_is_store = q_is_store[rd_ptr_reg];
    assign head_addr     = q_addr[rd_ptr_reg];
    assign head_wdata    = q_wdata[rd_ptr_reg];
    assign head_dest     = q_dest[rd_ptr_reg];

    // Only the acknowledge that matches the kind of access in flight counts.
    assign ack_match = head_is_store ? write_store_valid : read_load_valid;

    // Write the entry payload. Storage has no reset because the count qualifies every slot.
    always_ff @(posedge clk) begin
        if (push) begin
            q_is_store[wr_ptr_reg] <= req_is_store;
            q_addr[wr_ptr_reg]     <= req_addr;
            q_wdata[wr_ptr_reg]    <= req_wdata;
            q_dest[wr_ptr_reg]     <= req_dest;
        end
    end

    // Update the queue pointers and the occupancy count. A flush keeps only the in-flight head.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            if (state_reg != ST_IDLE) begin
                rd_ptr_reg <= pop ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;
                wr_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                count_reg  <= pop ? '0 : CNT_W'(1);
            end else begin
                wr_ptr_reg <= rd_ptr_reg;
                count_reg  <= '0;
            end
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (push && !pop) begin
                count_reg <= count_reg + CNT_W'(1);
            end else if (!push && pop) begin
                count_reg <= count_reg - CNT_W'(1);
            end
        end
    end

    // Compute the next FSM state and the next values of all registered outputs.
    always_comb begin
        state_next     = state_reg;
        wait_cnt_next  = wait_cnt_reg;
        pop            = 1'b0;
        mem_read_next  = 1'b0;
        mem_write_next = 1'b0;
        mem_adrs_next  = mem_adrs_reg;
        mem_wdata_next = mem_wdata_reg;
        wb_valid_next  = 1'b0;
        wb_dest_next   = wb_dest_reg;
        wb_data_next   = wb_data_reg;
        error_next     = error_reg;

        unique case (state_reg)
            ST_IDLE: begin
                mem_adrs_next  = '0;
                mem_wdata_next = '0;
                // A flush in IDLE empties the queue, so no issue is started that cycle.
                if ((count_reg != '0) && !flush) begin
                    state_next     = ST_ISSUE;
                    mem_read_next  = !head_is_store;
                    mem_write_next = head_is_store;
                    mem_adrs_next  = head_addr;
                    mem_wdata_next = head_is_store ? head_wdata : '0;
                end
            end
            ST_ISSUE: begin
                // Acknowledges during the strobe cycle are ignored.
                state_next    = ST_WAIT;
                wait_cnt_next = '0;
            end
            ST_WAIT: begin
                if (ack_match) begin
                    pop            = 1'b1;
                    state_next     = ST_IDLE;
                    mem_adrs_next  = '0;
                    mem_wdata_next = '0;
                    if (!head_is_store) begin
                        wb_valid_next = 1'b1;
                        wb_dest_next  = head_dest;
                        wb_data_next  = mem_rdata;
                    end
                end else if (wait_cnt_reg == TO_W'(TIMEOUT - 1)) begin
                    // Abandon the access. The entry is dropped and produces no writeback.
                    pop            = 1'b1;
                    error_next     = 1'b1;
                    state_next     = ST_IDLE;
                    mem_adrs_next  = '0;
                    mem_wdata_next = '0;
                end else begin
                    wait_cnt_next = wait_cnt_reg + TO_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Register the FSM state, the timeout counter and every output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            wait_cnt_reg  <= '0;
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
            mem_adrs_reg  <= '0;
            mem_wdata_reg <= '0;
            wb_valid_reg  <= 1'b0;
            wb_dest_reg   <= '0;
            wb_data_reg   <= '0;
            error_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wait_cnt_reg  <= wait_cnt_next;
            mem_read_reg  <= mem_read_next;
            mem_write_reg <= mem_write_next;
            mem_adrs_reg  <= mem_adrs_next;
            mem_wdata_reg <= mem_wdata_next;
            wb_valid_reg  <= wb_valid_next;
            wb_dest_reg   <= wb_dest_next;
            wb_data_reg   <= wb_data_next;
            error_reg     <= error_next;
        end
    end

    assign mem_read  = mem_read_reg;
    assign mem_write = mem_write_reg;
    assign mem_adrs  = mem_adrs_reg;
    assign mem_wdata = mem_wdata_reg;
    assign wb_valid  = wb_valid_reg;
    assign wb_dest   = wb_dest_reg;
    assign wb_data   = wb_data_reg;
    assign error     = error_reg;
    assign pending   = count_reg;
    assign busy      = (count_reg != '0);

endmodule

// File: tb/tb_cpu_lsu.sv
// Testbench for cpu_lsu (DEPTH=4, TIMEOUT=8).
// A memory responder acknowledges each strobe after a programmable delay.
// A scoreboard checks every strobe and every writeback pulse against
// expectations that are queued when each request is pushed.
module tb_cpu_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [10:0] req_addr;
    logic [31:0] req_wdata;
    logic [5:0]  req_dest;
    logic        mem_read;
    logic        mem_write;
    logic [10:0] mem_adrs;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        read_load_valid;
    logic        write_store_valid;
    logic        wb_valid;
    logic [5:0]  wb_dest;
    logic [31:0] wb_data;
    logic        busy;
    logic [2:0]  pending;
    logic        error;

    cpu_lsu #(.DATA_W(32), .ADDR_W(11), .DEST_W(6), .DEPTH(4), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_dest(req_dest),
        .mem_read(mem_read), .mem_write(mem_write), .mem_adrs(mem_adrs),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .read_load_valid(read_load_valid), .write_store_valid(write_store_valid),
        .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data),
        .busy(busy), .pending(pending), .error(error)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic        is_store;
        logic [10:0] addr;
        logic [31:0] wdata;
    } strobe_t;

    typedef struct packed {
        logic [5:0]  dest;
        logic [31:0] data;
    } wb_t;

    typedef struct {
        logic        is_store;
        logic [10:0] addr;
        logic [31:0] wdata;
        logic [5:0]  dest;
        logic [31:0] exp_data;
    } vec_t;

    strobe_t exp_strobe[$];
    wb_t     exp_wb[$];
    vec_t    vecs[9];

    // Memory responder state and the knobs that the test sequences set
    logic [31:0] tb_mem [2048];
    int          ack_delay    = 1;
    bit          no_ack_loads = 1'b0;
    bit          wrong_first  = 1'b0;
    bit          resp_active  = 1'b0;
    int          resp_cnt     = 0;
    bit          resp_is_store;
    logic [10:0] resp_addr;
    logic [31:0] resp_wdata;
    bit          wrong_done;
    int          rd_cycles    = 0;
    strobe_t     mon_s;
    wb_t         mon_w;

    // Memory responder: sees a strobe on a falling edge and acknowledges ack_delay cycles later
    always @(negedge clk) begin
        read_load_valid   = 1'b0;
        write_store_valid = 1'b0;
        mem_rdata         = '0;
        if (reset) begin
            resp_active = 1'b0;
        end else begin
            if (resp_active) begin
                resp_cnt--;
                if (resp_cnt <= 0) begin
                    if (!resp_is_store && wrong_first && !wrong_done) begin
                        write_store_valid = 1'b1;
                        wrong_done        = 1'b1;
                        resp_cnt          = 2;
                    end else if (resp_is_store) begin
                        tb_mem[resp_addr] = resp_wdata;
                        write_store_valid = 1'b1;
                        resp_active       = 1'b0;
                    end else begin
                        read_load_valid = 1'b1;
                        mem_rdata       = tb_mem[resp_addr];
                        resp_active     = 1'b0;
                    end
                end
            end
            if (mem_read || mem_write) begin
                resp_is_store = mem_write;
                resp_addr     = mem_adrs;
                resp_wdata    = mem_wdata;
                wrong_done    = 1'b0;
                resp_cnt      = ack_delay;
                resp_active   = !(mem_read && no_ack_loads);
            end
        end
    end

    // Scoreboard monitor: every strobe cycle and every writeback pulse is compared in order
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_read || mem_write) begin
                if (mem_read) rd_cycles++;
                tests++;
                if (exp_strobe.size() == 0) begin
                    fails++;
                    $display("FAIL strobe_unexpected: got rd=%0b wr=%0b adrs=%h, required no strobe",
                             mem_read, mem_write, mem_adrs);
                end else begin
                    mon_s = exp_strobe.pop_front();
                    if (mem_write !== mon_s.is_store || mem_read !== !mon_s.is_store ||
                        mem_adrs !== mon_s.addr || (mon_s.is_store && mem_wdata !== mon_s.wdata)) begin
                        fails++;
                        $display("FAIL strobe: got rd=%0b wr=%0b adrs=%h wdata=%h, required store=%0b adrs=%h wdata=%h",
                                 mem_read, mem_write, mem_adrs, mem_wdata,
                                 mon_s.is_store, mon_s.addr, mon_s.wdata);
                    end else begin
                        $display("[TB] strobe %s adrs=%h", mem_write ? "store" : "load ", mem_adrs);
                    end
                end
            end
            if (wb_valid) begin
                tests++;
                if (exp_wb.size() == 0) begin
                    fails++;
                    $display("FAIL wb_unexpected: got dest=%h data=%h, required no writeback", wb_dest, wb_data);
                end else begin
                    mon_w = exp_wb.pop_front();
                    if (wb_dest !== mon_w.dest || wb_data !== mon_w.data) begin
                        fails++;
                        $display("FAIL wb: got dest=%h data=%h, required dest=%h data=%h",
                                 wb_dest, wb_data, mon_w.dest, mon_w.data);
                    end else begin
                        $display("[TB] writeback dest=%h data=%h", wb_dest, wb_data);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Present one request at a falling edge once there is room, and queue its expected strobe and writeback
    task automatic push(input logic st, input logic [10:0] a, input logic [31:0] d,
                        input logic [5:0] dst, input logic [31:0] ed, input bit want_wb);
        int n = 0;
        while (!req_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("push_ready_timeout", {31'd0, req_ready}, 32'd1);
        req_valid    = 1'b1;
        req_is_store = st;
        req_addr     = a;
        req_wdata    = d;
        req_dest     = dst;
        exp_strobe.push_back('{is_store: st, addr: a, wdata: d});
        if (!st && want_wb) exp_wb.push_back('{dest: dst, data: ed});
        $display("[TB] push %s addr=%h wdata=%h dest=%h", st ? "store" : "load ", a, d, dst);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check({name, "_busy"}, {31'd0, busy}, 32'd0);
        check({name, "_strobes_left"}, exp_strobe.size(), 32'd0);
        check({name, "_wb_left"}, exp_wb.size(), 32'd0);
    endtask

    task automatic wait_strobe();
        int n = 0;
        while (!(mem_read || mem_write) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("strobe_wait_timeout", {31'd0, (mem_read | mem_write)}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0;
        int bad;
        logic [2:0] prev;

        for (int i = 0; i < 2048; i++) tb_mem[i] = 32'hA500_0000 + i;
        tb_mem[16] = 32'hDEAD_BEEF;

        vecs[0] = '{is_store: 1'b1, addr: 11'h001, wdata: 32'd5,          dest: 6'h00, exp_data: 32'h0};
        vecs[1] = '{is_store: 1'b0, addr: 11'h001, wdata: 32'h0,          dest: 6'h0A, exp_data: 32'd5};
        vecs[2] = '{is_store: 1'b1, addr: 11'h002, wdata: 32'd7,          dest: 6'h00, exp_data: 32'h0};
        vecs[3] = '{is_store: 1'b0, addr: 11'h002, wdata: 32'h0,          dest: 6'h0B, exp_data: 32'd7};
        vecs[4] = '{is_store: 1'b1, addr: 11'h7FF, wdata: 32'h1234_5678,  dest: 6'h00, exp_data: 32'h0};
        vecs[5] = '{is_store: 1'b0, addr: 11'h7FF, wdata: 32'h0,          dest: 6'h3F, exp_data: 32'h1234_5678};
        vecs[6] = '{is_store: 1'b0, addr: 11'h000, wdata: 32'h0,          dest: 6'h20, exp_data: 32'hA500_0000};
        vecs[7] = '{is_store: 1'b1, addr: 11'h400, wdata: 32'h0BAD_F00D,  dest: 6'h00, exp_data: 32'h0};
        vecs[8] = '{is_store: 1'b0, addr: 11'h400, wdata: 32'h0,          dest: 6'h01, exp_data: 32'h0BAD_F00D};

        reset = 1'b1; flush = 1'b0; req_valid = 1'b0; req_is_store = 1'b0;
        req_addr = '0; req_wdata = '0; req_dest = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_ready",   {31'd0, req_ready}, 32'd1);
        check("reset_pending", {29'd0, pending},   32'd0);
        check("reset_busy",    {31'd0, busy},      32'd0);
        check("reset_error",   {31'd0, error},     32'd0);
        check("reset_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        check("reset_adrs",    {21'd0, mem_adrs},  32'd0);

        // Single load: ack three cycles after the strobe, exactly one read strobe cycle
        ack_delay = 3;
        rd0 = rd_cycles;
        push(1'b0, 11'h010, 32'h0, 6'h25, 32'hDEAD_BEEF, 1'b1);
        wait_idle("single_load");
        check("single_load_read_cycles", rd_cycles - rd0, 32'd1);

        // Four back-to-back requests fill the queue; loads return the stored values in order
        for (int i = 0; i < 4; i++)
            push(vecs[i].is_store, vecs[i].addr, vecs[i].wdata, vecs[i].dest, vecs[i].exp_data, 1'b1);
        check("full_ready",   {31'd0, req_ready}, 32'd0);
        check("full_pending", {29'd0, pending},   32'd4);
        bad  = 0;
        prev = pending;
        for (int n = 0; n < 200 && busy; n++) begin
            @(negedge clk);
            if (pending > prev) bad++;
            prev = pending;
        end
        check("drain_monotonic", bad, 32'd0);
        check("drain_pending",   {29'd0, pending}, 32'd0);
        wait_idle("fill4");

        // Longer stream that wraps the pointers and hits backpressure with fast acks
        ack_delay = 1;
        for (int i = 4; i < 9; i++)
            push(vecs[i].is_store, vecs[i].addr, vecs[i].wdata, vecs[i].dest, vecs[i].exp_data, 1'b1);
        wait_idle("stream");

        // Timeout: the load is never acked; error rises after 8 WAIT cycles, and the next store still issues
        no_ack_loads = 1'b1;
        push(1'b0, 11'h055, 32'h0, 6'h03, 32'h0, 1'b0);
        push(1'b1, 11'h056, 32'h0000_CAFE, 6'h00, 32'h0, 1'b0);
        wait_strobe();
        repeat (8) @(negedge clk);
        check("timeout_error_early", {31'd0, error}, 32'd0);
        @(negedge clk);
        check("timeout_error_set",   {31'd0, error}, 32'd1);
        wait_idle("timeout");
        no_ack_loads = 1'b0;

        // Flush while the first of three loads waits; a push in the flush cycle is discarded
        ack_delay = 6;
        push(1'b0, 11'h030, 32'h0, 6'h04, 32'hA500_0030, 1'b1);
        push(1'b0, 11'h031, 32'h0, 6'h05, 32'hA500_0031, 1'b1);
        push(1'b0, 11'h032, 32'h0, 6'h06, 32'hA500_0032, 1'b1);
        flush        = 1'b1;
        req_valid    = 1'b1;
        req_is_store = 1'b1;
        req_addr     = 11'h033;
        req_wdata    = 32'h5555_5555;
        @(negedge clk);
        flush     = 1'b0;
        req_valid = 1'b0;
        void'(exp_strobe.pop_back());
        void'(exp_strobe.pop_back());
        void'(exp_wb.pop_back());
        void'(exp_wb.pop_back());
        check("flush_pending", {29'd0, pending}, 32'd1);
        wait_idle("flush");
        repeat (5) @(negedge clk);

        // A store ack during a load WAIT is ignored; only the read ack completes the load
        ack_delay   = 1;
        wrong_first = 1'b1;
        push(1'b0, 11'h020, 32'h0, 6'h11, 32'hA500_0020, 1'b1);
        wait_strobe();
        repeat (2) @(negedge clk);
        check("wrong_ack_pending", {29'd0, pending}, 32'd1);
        wait_idle("wrong_ack");
        wrong_first = 1'b0;
        check("error_sticky", {31'd0, error}, 32'd1);

        // Reset in the middle of a load WAIT
        no_ack_loads = 1'b1;
        push(1'b0, 11'h123, 32'h0, 6'h01, 32'h0, 1'b0);
        wait_strobe();
        @(negedge clk);
        check("midwait_adrs_held", {21'd0, mem_adrs}, 32'h123);
        #2 reset = 1'b1;
        #1;
        check("areset_adrs",    {21'd0, mem_adrs}, 32'd0);
        check("areset_pending", {29'd0, pending},  32'd0);
        check("areset_busy",    {31'd0, busy},     32'd0);
        check("areset_error",   {31'd0, error},    32'd0);
        check("areset_ready",   {31'd0, req_ready}, 32'd1);
        check("areset_wb",      {31'd0, wb_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        no_ack_loads = 1'b0;
        repeat (20) @(negedge clk);
        check("post_reset_pending", {29'd0, pending}, 32'd0);
        check("post_reset_strobes_left", exp_strobe.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
